mouse_status_display: RTL and testbench

Parametrised status-display controller for the mouse interface debug top. It stretches single-cycle mouse events (left click, cheat activate, and so on) into visible LED pulses across `CH` channels, with optional retrigger. It also converts a selected mouse coordinate to decimal through a sequential double-dabble engine, so no divider is used. It drives the existing `SevenSegment` block through a 16-bit `nums` word and sits between `MouseInterface_top` and the board LEDs / seven-segment display.

---
 rtl/mouse_status_display.sv | 139 +++++++++++++
 tb/tb_mouse_status_display.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_status_display.sv
// Status-display controller: per-channel event pulse stretchers driving LEDs,
// plus a continuously running double-dabble converter that turns the selected
// mouse coordinate into three BCD digits for the SevenSegment block.
//
// Handshake: nums_valid is a one-cycle strobe with no ready. It is high in the
// cycle after nums/overflow were written, and those values hold until the next
// strobe.
//
// The event input is named events because event is a SystemVerilog keyword.
module mouse_status_display #(
  parameter int CH          = 3,
  parameter int HOLD_CYCLES = 33554432,
  parameter int RETRIGGER   = 1,
  parameter int COORD_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH-1:0]      events,
  input  logic [COORD_W-1:0] coord_x,
  input  logic [COORD_W-1:0] coord_y,
  input  logic               sel,
  output logic [CH-1:0]      led,
  output logic [15:0]        nums,
  output logic               nums_valid,
  output logic               overflow,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0] ITER_LAST = 4'(COORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  logic [CNT_W-1:0]      cnt [CH];
  state_t                state, state_nxt;
  logic [COORD_W-1:0]    sh;
  logic                  sel_cap;
  logic [15:0]           bcd;
  logic [15:0]           bcd_adj;
  logic [16+COORD_W-1:0] shifted;
  logic [3:0]            iter;

  // Pulse stretchers: each channel lights on an event and counts out its hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!led[i]) begin
          if (events[i]) begin
            led[i] <= 1'b1;
            cnt[i] <= '0;
          end
        end else if (events[i] && (RETRIGGER != 0)) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          led[i] <= 1'b0;
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Converter state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Converter next-state: IDLE -> SHIFT (COORD_W cycles) -> UPDATE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_SHIFT;
      S_SHIFT:  if (iter == ITER_LAST) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift {bcd, sh} left.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
    shifted = {bcd_adj, sh} << 1;
  end

  // Converter datapath and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      sel_cap    <= 1'b0;
      bcd        <= '0;
      iter       <= '0;
      nums       <= '0;
      nums_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      nums_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          sh      <= sel ? coord_x : coord_y;
          sel_cap <= sel;
          bcd     <= '0;
          iter    <= '0;
        end
        S_SHIFT: begin
          bcd  <= shifted[16+COORD_W-1:COORD_W];
          sh   <= shifted[COORD_W-1:0];
          iter <= iter + 4'd1;
        end
        S_UPDATE: begin
          if (bcd[15:12] != 4'd0) begin
            nums     <= {3'b000, sel_cap, 4'd9, 4'd9, 4'd9};
            overflow <= 1'b1;
          end else begin
            nums     <= {3'b000, sel_cap, bcd[11:0]};
            overflow <= 1'b0;
          end
          nums_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mouse_status_display.sv
// Directed bench for mouse_status_display: two instances with HOLD_CYCLES=8,
// one retriggering and one not, sharing all inputs.
module tb_mouse_status_display;

  localparam int CH = 3;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] events;
  logic [CW-1:0] coord_x, coord_y;
  logic          sel;
  logic [CH-1:0] led, led_nr;
  logic [15:0]   nums, nums_nr;
  logic          nums_valid, nums_valid_nr;
  logic          overflow, overflow_nr;
  logic [1:0]    dbg_state, dbg_state_nr;

  int total = 0;
  int bad   = 0;

  // Clock and DUTs.
  always #5 clk = ~clk;

  mouse_status_display #(.CH(CH), .HOLD_CYCLES(8), .RETRIGGER(1), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .events(events), .coord_x(coord_x), .coord_y(coord_y),
    .sel(sel), .led(led), .nums(nums), .nums_valid(nums_valid),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  mouse_status_display #(.CH(CH), .HOLD_CYCLES(8), .RETRIGGER(0), .COORD_W(CW)) dut_nr (
    .clk(clk), .rst(rst), .events(events), .coord_x(coord_x), .coord_y(coord_y),
    .sel(sel), .led(led_nr), .nums(nums_nr), .nums_valid(nums_valid_nr),
    .overflow(overflow_nr), .dbg_state(dbg_state_nr)
  );

  // Advance to the next negedge at which nums_valid is high, within a budget.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (nums_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; events = '0; coord_x = 10'd637; coord_y = 10'd479; sel = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (led !== 3'b000 || nums !== 16'h0000 || overflow !== 1'b0 ||
        nums_valid !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_values: led=%b nums=%h ov=%b nv=%b st=%0d want 000/0000/0/0/0",
               led, nums, overflow, nums_valid, dbg_state);
    end
  endtask

  // First strobe exactly CW+2 cycles after the first IDLE cycle.
  task automatic test_first_latency;
    int seen_at;
    seen_at = -1;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (nums_valid && seen_at < 0) seen_at = k;
    end
    total++;
    if (seen_at !== CW + 2) begin
      bad++;
      $display("FAIL first_valid_latency: got %0d want %0d", seen_at, CW + 2);
    end
  endtask

  task automatic test_conversion;
    logic [CW-1:0] vx [4]   = '{10'd637, 10'd5, 10'd1023, 10'd0};
    logic [CW-1:0] vy [4]   = '{10'd3,   10'd0, 10'd479,  10'd999};
    logic          vs [4]   = '{1'b1,    1'b0,  1'b0,     1'b0};
    logic [15:0]   en [4]   = '{16'h1637, 16'h0000, 16'h0479, 16'h0999};
    logic          eo [4]   = '{1'b0,    1'b0,  1'b0,     1'b0};
    bit ok1, ok2;
    for (int v = 0; v < 4; v++) begin
      coord_x = vx[v]; coord_y = vy[v]; sel = vs[v];
      wait_valid(ok1);
      wait_valid(ok2);
      total++;
      if (!ok1 || !ok2) begin
        bad++;
        $display("FAIL conv_timeout_%0d: nums_valid not seen", v);
      end
      total++;
      if (nums !== en[v] || overflow !== eo[v]) begin
        bad++;
        $display("FAIL conv_%0d: nums=%h ov=%b want %h/%b", v, nums, overflow, en[v], eo[v]);
      end
    end
    coord_x = 10'd1023; sel = 1'b1;
    wait_valid(ok1);
    wait_valid(ok2);
    total++;
    if (!ok1 || !ok2 || nums !== 16'h1999 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL conv_overflow: nums=%h ov=%b ok=%b%b want 1999/1", nums, overflow, ok1, ok2);
    end
  endtask

  // Period between strobes is CW+2 cycles.
  task automatic test_period;
    bit ok;
    int gap;
    wait_valid(ok);
    gap = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (nums_valid) begin
        gap = k;
        break;
      end
    end
    total++;
    if (!ok || gap !== CW + 2) begin
      bad++;
      $display("FAIL valid_period: got %0d want %0d", gap, CW + 2);
    end
  endtask

  task automatic test_sel_toggle;
    bit ok;
    coord_x = 10'd100; coord_y = 10'd200; sel = 1'b1;
    wait_valid(ok);
    wait_valid(ok);
    repeat (3) @(negedge clk);
    sel = 1'b0;
    wait_valid(ok);
    total++;
    if (!ok || nums !== 16'h1100) begin
      bad++;
      $display("FAIL sel_toggle_old: nums=%h want 1100", nums);
    end
    wait_valid(ok);
    total++;
    if (!ok || nums !== 16'h0200) begin
      bad++;
      $display("FAIL sel_toggle_new: nums=%h want 0200", nums);
    end
  endtask

  task automatic test_single_pulse;
    int errs;
    errs = 0;
    @(negedge clk);
    events = 3'b001;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) events = '0;
      if (led[0] !== (k < 8) || led[2:1] !== 2'b00 ||
          led_nr[0] !== (k < 8) || led_nr[2:1] !== 2'b00) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL single_pulse: %0d bad samples (led=%b led_nr=%b)", errs, led, led_nr);
    end
  endtask

  task automatic test_retrigger;
    int errs_r, errs_nr;
    errs_r = 0; errs_nr = 0;
    @(negedge clk);
    events = 3'b010;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (led[1] !== (k < 13)) errs_r++;
      if (led_nr[1] !== (k < 8)) errs_nr++;
      if (k == 0) events = '0;
      if (k == 4) events = 3'b010;
      if (k == 5) events = '0;
    end
    total++;
    if (errs_r != 0) begin
      bad++;
      $display("FAIL retrigger_on: %0d bad samples of led[1], want high 13 cycles", errs_r);
    end
    total++;
    if (errs_nr != 0) begin
      bad++;
      $display("FAIL retrigger_off: %0d bad samples of led[1], want high 8 cycles", errs_nr);
    end
  endtask

  // Held event level and simultaneous channels.
  task automatic test_back_to_back;
    int errs;
    errs = 0;
    @(negedge clk);
    events = 3'b111;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) events = '0;
      if (led !== ((k < 10) ? 3'b111 : 3'b000)) errs++;
      if (led_nr !== ((k < 8) ? 3'b111 : 3'b000)) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL held_level_all_channels: %0d bad samples led=%b led_nr=%b", errs, led, led_nr);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int seen_at;
    coord_x = 10'd42; sel = 1'b1;
    wait_valid(ok);
    events = 3'b101;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (led !== 3'b000 || led_nr !== 3'b000 || nums !== 16'h0000 || overflow !== 1'b0 ||
        nums_valid !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: led=%b led_nr=%b nums=%h ov=%b nv=%b st=%0d want all zero",
               led, led_nr, nums, overflow, nums_valid, dbg_state);
    end
    rst = 1'b0; events = '0;
    seen_at = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (nums_valid && seen_at < 0) seen_at = k;
      if (seen_at < 0 && nums !== 16'h0000) seen_at = 100;
    end
    total++;
    if (seen_at !== CW + 2 || nums !== 16'h1042) begin
      bad++;
      $display("FAIL reset_recover: first valid at %0d nums=%h want %0d/1042", seen_at, nums, CW + 2);
    end
  endtask

  initial begin
    test_reset();
    test_first_latency();
    test_conversion();
    test_period();
    test_sel_toggle();
    test_single_pulse();
    test_retrigger();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
